chan_arb_mux: RTL
=================

CHAN_ARB_MUX -- requirements
Module: chan_arb_mux

Interface
REQ-001 Parameter WIDTH, default 8, is the data width per channel in bits.
REQ-002 Parameter NCH, default 4, is the number of input channels; legal range is 2..16.
REQ-003 Parameter SELW, default 2, is the channel-index width; it SHALL satisfy 2^SELW >= NCH.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in_data, input, NCH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, NCH bits: channel k presents data when bit k is 1.
REQ-008 Port in_ready, output, NCH bits: channel k's word is consumed on a rising edge where in_valid[k] and in_ready[k] are both 1.
REQ-009 Port mode, input, 2 bits: 00 = round-robin, 01 = fixed priority, 10 = forced select, 11 = hold (no grants).
REQ-010 Port sel, input, SELW bits: the channel index used in forced-select mode.
REQ-011 Port out_data, output, WIDTH bits: registered output word.
REQ-012 Port out_valid, output, 1 bit: out_data is valid when 1.
REQ-013 Port out_ready, input, 1 bit: the downstream sink accepts on a rising edge where out_valid and out_ready are both 1.
REQ-014 Port out_chan, output, SELW bits: the index of the channel that sourced out_data.

Function
REQ-015 The accept condition SHALL be: acc = !out_valid || out_ready.
REQ-016 Candidate grant by mode:
- Round-robin: the first valid channel found searching upward from ptr, with wrap-around.
- Fixed priority: the lowest-index valid channel.
- Forced select: channel sel, only if in_valid[sel] is 1.
- Hold: none.
REQ-017 In forced-select mode, sel >= NCH SHALL produce no grant.
REQ-018 in_ready SHALL be combinational and one-hot or zero; only the granted channel's bit may be 1, and only when acc is 1.
REQ-019 in_ready SHALL NOT depend on in_valid of the channel it drives except through grant selection; there SHALL be no combinational loop via out_ready beyond REQ-015.
REQ-020 On a grant, the next edge SHALL load out_data with the granted word, set out_chan to the granted index, and set out_valid to 1. Latency is one cycle, input handshake to out_valid.
REQ-021 When acc is 1 and there is no grant, the next edge SHALL clear out_valid; out_data and out_chan keep their previous values.
REQ-022 While out_valid is 1 and out_ready is 0, out_data, out_chan and out_valid SHALL hold stable, and all in_ready bits SHALL be 0.
REQ-023 With sustained out_ready = 1 and a continuous grant, throughput SHALL be one word per cycle with no bubbles.
REQ-024 Round-robin pointer ptr (SELW bits): on every grant, in any mode, ptr SHALL become (granted index + 1) mod NCH; with no grant it is unchanged.
REQ-025 A mode or sel change SHALL take effect on the same cycle's grant computation. A word already in the output register SHALL be unaffected.
REQ-026 Mode 11 SHALL drain the output register normally but accept nothing new.

Reset
REQ-027 While rst is 1, out_valid = 0, out_data = 0, out_chan = 0 and ptr = 0, asynchronously; in_ready SHALL be all 0.
REQ-028 Reset asserted mid-transfer SHALL discard the held word. The first grant after reset release SHALL follow the reset-state ptr = 0.

Verification
REQ-029 Round-robin fairness: NCH=4, mode=00, all in_valid=1, out_ready=1 held. Expect out_chan sequence 0,1,2,3,0,... and one word per cycle.
REQ-030 Fixed priority: mode=01, in_valid=4'b1010. Expect out_chan=1 repeatedly; after in_valid[1] drops, out_chan=3.
REQ-031 Backpressure: out_valid=1 with data 0xA5, out_ready=0 for 3 cycles, new inputs valid. Expect out_data stays 0xA5, in_ready=0, no input consumed; the accept occurs on the cycle out_ready=1.
REQ-032 Forced select: mode=10, sel=2, in_valid=4'b1111 gives only channel 2 granted. sel=5 with NCH=4 gives in_ready=0 and out_valid falling to 0 after the drain.
REQ-033 Async reset mid-stream: rst pulsed between clock edges while out_valid=1. Expect out_valid=0 immediately; after release, with all channels valid in mode=00, the first out_chan=0.
REQ-034 Wrap-around and sparse traffic: ptr=3, in_valid=4'b0001 gives a grant of 0 and ptr becoming 1. Idle cycles (no valid inputs) give out_valid=0 and no change to ptr.

Source files
------------

// File: rtl/chan_arb_mux_if.sv
// Channel-side and sink-side handshake bundle for chan_arb_mux.
// slave = the arbiter's view, master = the driver/sink view.
interface chan_arb_mux_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [1:0]           mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_chan;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/chan_arb_mux.sv
// N-channel arbiter/mux into a single registered output slot.
// Modes: round-robin, fixed priority, forced select, hold.
module chan_arb_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    chan_arb_mux_if.slave bus
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             acc;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [NCH-1:0]   ready;

    // Slot can take a word when empty or being drained this edge.
    assign acc = !out_valid_q || bus.out_ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        case (bus.mode)
            2'b00: begin
                for (int i = 0; i < NCH; i++) begin
                    if (!gnt_vld && bus.in_valid[(int'(ptr_q) + i) % NCH]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'((int'(ptr_q) + i) % NCH);
                    end
                end
            end
            2'b01: begin
                for (int i = NCH - 1; i >= 0; i--) begin
                    if (bus.in_valid[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'(i);
                    end
                end
            end
            2'b10: begin
                // Out-of-range sel never matches any channel, so no grant.
                for (int i = 0; i < NCH; i++) begin
                    if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'(i);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        gnt_data = '0;
        ready    = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_idx == SELW'(k)) begin
                gnt_data = bus.in_data[k*WIDTH +: WIDTH];
                ready[k] = acc && gnt_vld && !rst;
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (acc) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = gnt_data;
                out_chan_d = gnt_idx;
                ptr_d      = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
endmodule
